// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default parameters for the parametrised synchronous FIFO.
package fifo_pkg;

   localparam int DEF_DATA_W = 4;
   localparam int DEF_DEPTH  = 8;
   localparam int DEF_AF     = 6;
   localparam int DEF_AE     = 2;

   // Smallest r with 2**r >= value; elaboration-time only.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write port, asynchronous read port, no reset on the array.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int  DATA_W = DEF_DATA_W,
   parameter int  DEPTH  = DEF_DEPTH,
   localparam int AW     = clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, threshold flags, sticky
// error flags and selectable registered or first-word-fall-through read.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int  DATA_W    = DEF_DATA_W,
   parameter int  DEPTH     = DEF_DEPTH,
   parameter int  AF_THRESH = DEF_AF,
   parameter int  AE_THRESH = DEF_AE,
   parameter int  FWFT      = 0,
   localparam int AW        = clog2(DEPTH),
   localparam int PW        = AW + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_rq,
   input  logic [DATA_W-1:0] wdata,
   input  logic              rd_rq,
   output logic [DATA_W-1:0] rdata,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [PW-1:0]     count,
   output logic              overflow,
   output logic              underflow,
   input  logic              clr_err
);

   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
   localparam logic [PW-1:0] AF_P    = PW'(AF_THRESH);
   localparam logic [PW-1:0] AE_P    = PW'(AE_THRESH);

   logic [PW-1:0]     wr_ptr_reg;
   logic [PW-1:0]     rd_ptr_reg;
   logic              overflow_reg;
   logic              underflow_reg;
   logic              rd_acc;
   logic              wr_acc;
   logic [DATA_W-1:0] mem_rdata;

   // The extra wrap bit lets the pointer difference span 0..DEPTH without ambiguity.
   assign count        = wr_ptr_reg - rd_ptr_reg;
   assign empty        = (count == '0);
   assign full         = (count == DEPTH_P);
   assign almost_full  = (count >= AF_P);
   assign almost_empty = (count <= AE_P);

   // A full FIFO still takes a write when a read frees a slot in the same cycle.
   assign rd_acc = rd_rq & ~empty;
   assign wr_acc = wr_rq & (~full | rd_acc);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (rd_acc) rd_ptr_reg <= rd_ptr_reg + PW'(1);
         if (wr_rq & ~wr_acc)  overflow_reg <= 1'b1;
         else if (clr_err)     overflow_reg <= 1'b0;
         if (rd_rq & ~rd_acc)  underflow_reg <= 1'b1;
         else if (clr_err)     underflow_reg <= 1'b0;
      end
   end

   assign overflow  = overflow_reg;
   assign underflow = underflow_reg;

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc & ~rst),
      .waddr (wr_ptr_reg[AW-1:0]),
      .wdata (wdata),
      .raddr (rd_ptr_reg[AW-1:0]),
      .rdata (mem_rdata)
   );

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is shown directly; masked to zero so stale entries never leak out.
         assign rdata    = empty ? '0 : mem_rdata;
         assign rd_valid = ~empty;
      end else begin : g_reg
         logic [DATA_W-1:0] rdata_reg;
         logic              rd_valid_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               rdata_reg    <= '0;
               rd_valid_reg <= 1'b0;
            end else begin
               rd_valid_reg <= rd_acc;
               if (rd_acc) rdata_reg <= mem_rdata;
            end
         end

         assign rdata    = rdata_reg;
         assign rd_valid = rd_valid_reg;
      end
   endgenerate

endmodule
